// File: rtl/sipp_control.sv
// Moore control FSM sequencing fetch, decode and execute for the six-instruction SIPP datapath.
// Optional feature: define SIPP_HALT_ON_ILLEGAL_EN to park in HALT on an illegal opcode.
module sipp_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic        rf_p_zero,
    output logic        d_rd,
    output logic        d_wr,
    output logic        rf_w_wr,
    output logic        rf_p_rd,
    output logic        rf_q_rd,
    output logic        rf_p_addr_sel,
    output logic [1:0]  rf_w_data_sel,
    output logic        ir_ld,
    output logic        pc_ld,
    output logic        pc_clr,
    output logic        pc_inc,
    output logic [1:0]  alu_s,
    output logic        halted
);

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_LDC   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_JMPZ  = 4'b0101;

    localparam logic       RF_RP_ADDR_SEL_A  = 1'b0;
    localparam logic       RF_RP_ADDR_SEL_B  = 1'b1;
    localparam logic [1:0] RF_W_DATA_SEL_ALU = 2'b00;
    localparam logic [1:0] RF_W_DATA_SEL_MEM = 2'b01;
    localparam logic [1:0] RF_W_DATA_SEL_IR  = 2'b10;
    localparam logic [1:0] ALU_FN_ADD        = 2'b00;
    localparam logic [1:0] ALU_FN_SUBTR      = 2'b01;

    typedef enum logic [3:0] {
        INIT   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        LOAD1  = 4'd3,
        LOAD2  = 4'd4,
        STORE  = 4'd5,
        ADD    = 4'd6,
        SUB    = 4'd7,
        LDC    = 4'd8,
        JMPZ   = 4'd9,
        JMP    = 4'd10
`ifdef SIPP_HALT_ON_ILLEGAL_EN
        , HALT = 4'd11
`endif
    } state_t;

    state_t state;
    state_t next_state;
    logic   pc_clr_q;
    logic   unused_ir;

    // Only the opcode field steers control; the operand fields go straight to the datapath.
    assign unused_ir = ^ir[11:0];

    always_comb begin
        next_state = state;
        case (state)
            INIT:   next_state = FETCH;
            FETCH:  next_state = DECODE;
            DECODE: begin
                case (ir[15:12])
                    OP_LOAD:  next_state = LOAD1;
                    OP_STORE: next_state = STORE;
                    OP_ADD:   next_state = ADD;
                    OP_LDC:   next_state = LDC;
                    OP_SUB:   next_state = SUB;
                    OP_JMPZ:  next_state = JMPZ;
`ifdef SIPP_HALT_ON_ILLEGAL_EN
                    default:  next_state = HALT;
`else
                    default:  next_state = FETCH;
`endif
                endcase
            end
            LOAD1:  next_state = LOAD2;
            LOAD2:  next_state = FETCH;
            STORE:  next_state = FETCH;
            ADD:    next_state = FETCH;
            SUB:    next_state = FETCH;
            LDC:    next_state = FETCH;
            JMPZ:   next_state = rf_p_zero ? JMP : FETCH;
            JMP:    next_state = FETCH;
`ifdef SIPP_HALT_ON_ILLEGAL_EN
            HALT:   next_state = HALT;
`endif
            default: next_state = INIT;
        endcase
    end

    // Outputs are decoded from the state being entered, so each strobe is a clean register bit.
    always_ff @(posedge clk) begin
        d_rd          <= 1'b0;
        d_wr          <= 1'b0;
        rf_w_wr       <= 1'b0;
        rf_p_rd       <= 1'b0;
        rf_q_rd       <= 1'b0;
        rf_p_addr_sel <= RF_RP_ADDR_SEL_A;
        rf_w_data_sel <= RF_W_DATA_SEL_ALU;
        ir_ld         <= 1'b0;
        pc_ld         <= 1'b0;
        pc_clr_q      <= 1'b0;
        pc_inc        <= 1'b0;
        alu_s         <= ALU_FN_ADD;
`ifdef SIPP_HALT_ON_ILLEGAL_EN
        halted        <= 1'b0;
`endif
        if (!rst) begin
            state    <= INIT;
            pc_clr_q <= 1'b1;
        end else begin
            state <= next_state;
            case (next_state)
                INIT:  pc_clr_q <= 1'b1;
                FETCH: begin
                    ir_ld  <= 1'b1;
                    pc_inc <= 1'b1;
                end
                LOAD1: d_rd <= 1'b1;
                LOAD2: begin
                    d_rd          <= 1'b1;
                    rf_w_wr       <= 1'b1;
                    rf_w_data_sel <= RF_W_DATA_SEL_MEM;
                end
                STORE: begin
                    rf_p_rd <= 1'b1;
                    d_wr    <= 1'b1;
                end
                ADD, SUB: begin
                    rf_p_rd       <= 1'b1;
                    rf_q_rd       <= 1'b1;
                    rf_p_addr_sel <= RF_RP_ADDR_SEL_B;
                    rf_w_wr       <= 1'b1;
                    alu_s         <= (next_state == SUB) ? ALU_FN_SUBTR : ALU_FN_ADD;
                end
                LDC: begin
                    rf_w_wr       <= 1'b1;
                    rf_w_data_sel <= RF_W_DATA_SEL_IR;
                end
                JMPZ:  rf_p_rd <= 1'b1;
                JMP:   pc_ld <= 1'b1;
`ifdef SIPP_HALT_ON_ILLEGAL_EN
                HALT:  halted <= 1'b1;
`endif
                default: ;
            endcase
        end
    end

    // Reset also clears the PC on the very edge that samples it.
    assign pc_clr = pc_clr_q | ~rst;

`ifndef SIPP_HALT_ON_ILLEGAL_EN
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_sipp_control.sv
// Directed-vector bench for sipp_control; outputs are packed into one vector and compared per cycle.
module tb_sipp_control;

    logic        clk;
    logic        rst;
    logic [15:0] ir;
    logic        rf_p_zero;
    logic        d_rd, d_wr, rf_w_wr, rf_p_rd, rf_q_rd, rf_p_addr_sel;
    logic [1:0]  rf_w_data_sel;
    logic        ir_ld, pc_ld, pc_clr, pc_inc;
    logic [1:0]  alu_s;
    logic        halted;

    int testCount = 0;
    int failCount = 0;

    // Layout: d_rd d_wr rf_w_wr rf_p_rd rf_q_rd rf_p_addr_sel rf_w_data_sel[1:0] ir_ld pc_ld pc_clr pc_inc alu_s[1:0] halted
    localparam logic [14:0] E_INIT   = 15'h0010;
    localparam logic [14:0] E_FETCH  = 15'h0048;
    localparam logic [14:0] E_DECODE = 15'h0000;
    localparam logic [14:0] E_LOAD1  = 15'h4000;
    localparam logic [14:0] E_LOAD2  = 15'h5080;
    localparam logic [14:0] E_STORE  = 15'h2800;
    localparam logic [14:0] E_ADD    = 15'h1E00;
    localparam logic [14:0] E_SUB    = 15'h1E02;
    localparam logic [14:0] E_LDC    = 15'h1100;
    localparam logic [14:0] E_JMPZ   = 15'h0800;
    localparam logic [14:0] E_JMP    = 15'h0020;
    localparam logic [14:0] E_HALT   = 15'h0001;

    logic [14:0] outVec;
    assign outVec = {d_rd, d_wr, rf_w_wr, rf_p_rd, rf_q_rd, rf_p_addr_sel, rf_w_data_sel,
                     ir_ld, pc_ld, pc_clr, pc_inc, alu_s, halted};

    sipp_control dut (
        .clk(clk), .rst(rst), .ir(ir), .rf_p_zero(rf_p_zero),
        .d_rd(d_rd), .d_wr(d_wr), .rf_w_wr(rf_w_wr), .rf_p_rd(rf_p_rd), .rf_q_rd(rf_q_rd),
        .rf_p_addr_sel(rf_p_addr_sel), .rf_w_data_sel(rf_w_data_sel),
        .ir_ld(ir_ld), .pc_ld(pc_ld), .pc_clr(pc_clr), .pc_inc(pc_inc),
        .alu_s(alu_s), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [14:0] got, input logic [14:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, settle, then compare the packed outputs.
    task automatic applyStimulus(input string tag, input logic [14:0] exp);
        @(posedge clk);
        #1;
        checkOutput(tag, outVec, exp);
    endtask

    initial begin
        rst       = 1'b0;
        ir        = 16'h0000;
        rf_p_zero = 1'b0;

        applyStimulus("reset1", E_INIT);
        applyStimulus("reset2", E_INIT);
        rst = 1'b1;
        applyStimulus("fetch_after_reset", E_FETCH);

        ir = 16'h3105;
        applyStimulus("ldc_decode", E_DECODE);
        applyStimulus("ldc_exec", E_LDC);
        applyStimulus("ldc_fetch", E_FETCH);

        ir = 16'h2211;
        applyStimulus("add_decode", E_DECODE);
        applyStimulus("add_exec", E_ADD);
        applyStimulus("add_fetch", E_FETCH);

        ir = 16'h4312;
        applyStimulus("sub_decode", E_DECODE);
        applyStimulus("sub_exec", E_SUB);
        applyStimulus("sub_fetch", E_FETCH);

        ir = 16'h0320;
        applyStimulus("load_decode", E_DECODE);
        applyStimulus("load1", E_LOAD1);
        applyStimulus("load2", E_LOAD2);
        applyStimulus("load_fetch", E_FETCH);

        ir = 16'h1340;
        applyStimulus("store_decode", E_DECODE);
        applyStimulus("store_exec", E_STORE);
        applyStimulus("store_fetch", E_FETCH);

        ir = 16'h5003;
        rf_p_zero = 1'b1;
        applyStimulus("jmpz_t_decode", E_DECODE);
        applyStimulus("jmpz_t_exec", E_JMPZ);
        applyStimulus("jmpz_t_jmp", E_JMP);
        applyStimulus("jmpz_t_fetch", E_FETCH);

        rf_p_zero = 1'b0;
        applyStimulus("jmpz_nt_decode", E_DECODE);
        applyStimulus("jmpz_nt_exec", E_JMPZ);
        applyStimulus("jmpz_nt_fetch", E_FETCH);

`ifdef SIPP_HALT_ON_ILLEGAL_EN
        ir = 16'h6000;
        applyStimulus("ill_decode", E_DECODE);
        for (int i = 0; i < 10; i++) applyStimulus("halt_hold", E_HALT);
        rst = 1'b0;
        #1;
        checkOutput("halt_rst_comb", outVec, E_HALT | E_INIT);
        applyStimulus("halt_rst_init", E_INIT);
        rst = 1'b1;
        applyStimulus("halt_rst_fetch", E_FETCH);
`else
        ir = 16'h6000;
        applyStimulus("ill6_decode", E_DECODE);
        applyStimulus("ill6_fetch", E_FETCH);
        ir = 16'hF000;
        applyStimulus("illF_decode", E_DECODE);
        applyStimulus("illF_fetch", E_FETCH);
`endif

        ir = 16'h0320;
        applyStimulus("abort_decode", E_DECODE);
        applyStimulus("abort_load1", E_LOAD1);
        rst = 1'b0;
        #1;
        checkOutput("abort_rst_comb", outVec, E_LOAD1 | E_INIT);
        applyStimulus("abort_init", E_INIT);
        applyStimulus("abort_init_hold", E_INIT);
        rst = 1'b1;
        applyStimulus("abort_fetch", E_FETCH);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
